// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port A arbiter: FSM states and read-return owner tags.
package dmem_arb_pkg;
    typedef enum logic {CPU_PRI, EXT_SLOT} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, external-master and memory port A signals around the arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the memory macro drive this side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/rd_return_pipe.sv
// RD_LAT-deep shift of owner tags; the head tag marks who owns mem_rdata this cycle.
module rd_return_pipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t push_tag,
    output owner_t head_tag
);
    owner_t tag_pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= OWN_NONE;
        end else begin
            tag_pipe[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign head_tag = tag_pipe[RD_LAT-1];
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares memory port A between the CPU MEM stage and an external master; the CPU has
// priority but may win at most MAX_CPU_RUN times in a row while the external master waits.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 1,
    parameter int MAX_CPU_RUN = 4
) (
    input logic                 clk,
    input logic                 rst,
    dmem_port_arbiter_if.slave  bus
);
    localparam int RUN_W = (MAX_CPU_RUN > 1) ? $clog2(MAX_CPU_RUN) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN - 1);

    arb_state_t       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             cpu_grant, ext_grant;
    owner_t           push_tag, head_tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CPU_PRI;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Grants are forced off in reset so memory can never see a write then.
    always_comb begin
        cpu_grant = 1'b0;
        ext_grant = 1'b0;
        state_d   = state_q;
        run_d     = run_q;
        if (rst) begin
            case (state_q)
                CPU_PRI: begin
                    cpu_grant = bus.cpu_req;
                    ext_grant = bus.ext_req & ~bus.cpu_req;
                end
                default: begin
                    ext_grant = bus.ext_req;
                    cpu_grant = bus.cpu_req & ~bus.ext_req;
                end
            endcase

            if (state_q == EXT_SLOT)
                state_d = CPU_PRI;
            else if (cpu_grant && bus.ext_req && run_q == RUN_MAX)
                state_d = EXT_SLOT;

            if (ext_grant || !bus.ext_req || state_q == EXT_SLOT)
                run_d = '0;
            else if (cpu_grant && run_q != RUN_MAX)
                run_d = run_q + RUN_W'(1);
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        push_tag      = OWN_NONE;
        if (cpu_grant) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            push_tag      = bus.cpu_we ? OWN_NONE : OWN_CPU;
        end else if (ext_grant) begin
            bus.mem_we    = bus.ext_we;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            push_tag      = bus.ext_we ? OWN_NONE : OWN_EXT;
        end
    end

    assign bus.cpu_stall = bus.cpu_req & ~cpu_grant;
    assign bus.ext_gnt   = bus.ext_req & ext_grant;

    rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_tag (push_tag),
        .head_tag (head_tag)
    );

    // The memory already delays q by RD_LAT, so both ports simply see it.
    assign bus.cpu_rvalid = (head_tag == OWN_CPU);
    assign bus.ext_rvalid = (head_tag == OWN_EXT);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.ext_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, reset-mid-read sequence, then
// random traffic checked against a streak-count arbitration model.
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 16, DATA_W = 16, RD_LAT = 1, MAX_CPU_RUN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_CPU_RUN(MAX_CPU_RUN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0002: return 16'h1111;
            16'h0003: return 16'h2222;
            default:  return a ^ 16'hA55A;
        endcase
    endfunction

    // Synchronous RAM, one cycle read latency; filled on the first clock edge.
    logic [15:0] ram [0:65535];
    logic        ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] = init_val(i[15:0]);
            ram_ready <= 1'b1;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    logic [15:0] ref_mem [0:65535];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cr, input logic cwe, input logic [15:0] ca,
                         input logic [15:0] cd, input logic er, input logic ewe,
                         input logic [15:0] ea, input logic [15:0] ed);
        rst = r;
        bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.ext_req = er; bus.ext_we = ewe; bus.ext_addr = ea; bus.ext_wdata = ed;
    endtask

    typedef struct {
        logic r, cr, cwe; logic [15:0] ca, cd;
        logic er, ewe;    logic [15:0] ea, ed;
        logic stall, gnt, mwe; logic [15:0] maddr, mwd;
        logic crv, erv;   logic [15:0] rd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic cr, input logic cwe, input logic [15:0] ca, input logic [15:0] cd,
        input logic er, input logic ewe, input logic [15:0] ea, input logic [15:0] ed,
        input logic stall, input logic gnt, input logic mwe, input logic [15:0] maddr,
        input logic [15:0] mwd, input logic crv, input logic erv, input logic [15:0] rd);
        vec_t v;
        v.r = r; v.cr = cr; v.cwe = cwe; v.ca = ca; v.cd = cd;
        v.er = er; v.ewe = ewe; v.ea = ea; v.ed = ed;
        v.stall = stall; v.gnt = gnt; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd;
        v.crv = crv; v.erv = erv; v.rd = rd;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int   streak;
        logic cr_hold, er_hold, cpu_g, ext_g, prio;
        logic pend_cpu, pend_ext;
        logic [15:0] pend_d, e_addr, e_wd;
        logic e_we;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i[15:0]);

        // Reset held with both requesters asking (including writes).
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1,1,16'h0010,16'hFFFF, 1,1,16'h0011,16'hEEEE,
                              0,0,0,16'h0000,16'h0000, 0,0,16'h0));
        // CPU-only read of 0x0010.
        vecs.push_back(mk(1, 1,0,16'h0010,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0010,16'h0, 0,0,16'h0));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 1,0,16'hBEEF));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,0,16'h0));
        // Both held: CPU x4 then EXT, twice.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                vecs.push_back(mk(1, 1,1,16'h0030,16'h1234, 1,1,16'h0031,16'h5678,
                                  1,1,1,16'h0031,16'h5678, 0,0,16'h0));
            else
                vecs.push_back(mk(1, 1,1,16'h0030,16'h1234, 1,1,16'h0031,16'h5678,
                                  0,0,1,16'h0030,16'h1234, 0,0,16'h0));
        end
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,0,16'h0));
        // Interleaved CPU then EXT reads.
        vecs.push_back(mk(1, 1,0,16'h0002,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0002,16'h0, 0,0,16'h0));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 1,0,16'h0003,16'h0, 0,1,0,16'h0003,16'h0, 1,0,16'h1111));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,1,16'h2222));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,0,16'h0));
        // EXT write then CPU read-back.
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 1,1,16'h0040,16'h00A5, 0,1,1,16'h0040,16'h00A5, 0,0,16'h0));
        vecs.push_back(mk(1, 1,0,16'h0040,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0040,16'h0, 0,0,16'h0));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 1,0,16'h00A5));
        // Simultaneous reads: CPU first, EXT waits one cycle.
        vecs.push_back(mk(1, 1,0,16'h0002,16'h0, 1,0,16'h0003,16'h0, 0,0,0,16'h0002,16'h0, 0,0,16'h0));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 1,0,16'h0003,16'h0, 0,1,0,16'h0003,16'h0, 1,0,16'h1111));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,1,16'h2222));
        vecs.push_back(mk(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,0,16'h0));

        drive(0, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].cr, vecs[i].cwe, vecs[i].ca, vecs[i].cd,
                  vecs[i].er, vecs[i].ewe, vecs[i].ea, vecs[i].ed);
            @(negedge clk);
            if (vecs[i].r) chk($sformatf("vec%0d_stall", i), bus.cpu_stall, vecs[i].stall);
            chk($sformatf("vec%0d_gnt", i),   bus.ext_gnt,   vecs[i].gnt);
            chk($sformatf("vec%0d_we", i),    bus.mem_we,    vecs[i].mwe);
            chk($sformatf("vec%0d_addr", i),  bus.mem_addr,  vecs[i].maddr);
            chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vecs[i].mwd);
            chk($sformatf("vec%0d_crv", i),   bus.cpu_rvalid, vecs[i].crv);
            chk($sformatf("vec%0d_erv", i),   bus.ext_rvalid, vecs[i].erv);
            if (vecs[i].crv) chk($sformatf("vec%0d_crd", i), bus.cpu_rdata, vecs[i].rd);
            if (vecs[i].erv) chk($sformatf("vec%0d_erd", i), bus.ext_rdata, vecs[i].rd);
            @(posedge clk); #1;
        end

        // Reset lands on the edge right after a CPU read grant; EXT asks only during reset.
        drive(1, 1,0,16'h0010,16'h0, 0,0,16'h0,16'h0);
        @(negedge clk);
        chk("midrst_grant_addr", bus.mem_addr, 16'h0010);
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 16'h0050; bus.ext_wdata = 16'h9999;
        #1;
        chk("midrst_we_in_reset", bus.mem_we, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_crv", bus.cpu_rvalid, 1'b0);
        chk("midrst_gnt", bus.ext_gnt, 1'b0);
        @(posedge clk); #1;
        drive(1, 0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_crv", i), bus.cpu_rvalid, 1'b0);
            chk($sformatf("postrst%0d_erv", i), bus.ext_rvalid, 1'b0);
            chk($sformatf("postrst%0d_we", i),  bus.mem_we, 1'b0);
            @(posedge clk); #1;
        end
        chk("midrst_no_ext_write", ram[16'h0050], init_val(16'h0050));

        // Random traffic in 0x0100..0x013F against the reference model.
        streak = 0; cr_hold = 0; er_hold = 0; pend_cpu = 0; pend_ext = 0; pend_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!cr_hold) begin
                bus.cpu_req   = ($urandom % 4) != 0;
                bus.cpu_we    = $urandom % 2;
                bus.cpu_addr  = 16'h0100 + 16'($urandom % 64);
                bus.cpu_wdata = 16'($urandom);
            end
            if (er_hold) begin
                if ($urandom % 8 == 0) bus.ext_req = 1'b0;
            end else begin
                bus.ext_req   = $urandom % 2;
                bus.ext_we    = $urandom % 2;
                bus.ext_addr  = 16'h0100 + 16'($urandom % 64);
                bus.ext_wdata = 16'($urandom);
            end
            @(negedge clk);

            prio  = (streak >= MAX_CPU_RUN);
            cpu_g = prio ? (bus.cpu_req & ~bus.ext_req) : bus.cpu_req;
            ext_g = prio ? bus.ext_req : (bus.ext_req & ~bus.cpu_req);
            e_we = 0; e_addr = '0; e_wd = '0;
            if (cpu_g) begin e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata; end
            else if (ext_g) begin e_we = bus.ext_we; e_addr = bus.ext_addr; e_wd = bus.ext_wdata; end

            chk("rnd_stall", bus.cpu_stall, bus.cpu_req & ~cpu_g);
            chk("rnd_gnt",   bus.ext_gnt,   ext_g);
            chk("rnd_we",    bus.mem_we,    e_we);
            chk("rnd_addr",  bus.mem_addr,  e_addr);
            chk("rnd_wdata", bus.mem_wdata, e_wd);
            chk("rnd_crv",   bus.cpu_rvalid, pend_cpu);
            chk("rnd_erv",   bus.ext_rvalid, pend_ext);
            if (pend_cpu) chk("rnd_crd", bus.cpu_rdata, pend_d);
            if (pend_ext) chk("rnd_erd", bus.ext_rdata, pend_d);

            pend_cpu = cpu_g & ~bus.cpu_we;
            pend_ext = ext_g & ~bus.ext_we;
            if ((cpu_g || ext_g) && !e_we) pend_d = ref_mem[e_addr];
            if (e_we) ref_mem[e_addr] = e_wd;
            if (ext_g || !bus.ext_req || prio) streak = 0;
            else if (cpu_g) streak++;
            cr_hold = bus.cpu_req & ~cpu_g;
            er_hold = bus.ext_req & ~ext_g;
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
